elastic_pipe: RTL and testbench

//  Parametrised multi-stage pipeline register with valid/ready handshake, bubble collapsing,

---
 rtl/elastic_pipe_if.sv | 21 ++
 rtl/elastic_pipe.sv | 89 ++++++++
 tb/tb_elastic_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/elastic_pipe_if.sv
// Handshake bundle for elastic_pipe: upstream in_* and downstream out_* sides.
interface elastic_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master drives the pipe (producer + consumer side); slave is the pipe itself
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/elastic_pipe.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush and
// registered occupancy count. out_data comes straight from the last stage.
module elastic_pipe_stage #(
  parameter int WIDTH      = 16,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= 1'b0;
      if (RESET_DATA) d <= '0;
    end else if (adv) begin
      v <= v_in;
      d <= d_in;
    end
  end
endmodule

module elastic_pipe #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 2,
  parameter bit RESET_DATA = 1'b1,
  localparam int OW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  output logic [OW-1:0] occupancy,
  elastic_pipe_if.slave bus
);
  logic [DEPTH-1:0]            v, adv, v_in;
  logic [DEPTH-1:0][WIDTH-1:0] d, d_in;
  logic                        in_xfer, out_xfer;

  // A stage may move whenever it is empty or everything downstream of it moves,
  // so bubbles are always overwritten.
  always_comb begin
    logic a;
    a = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a      = !v[i] | a;
      adv[i] = a;
    end
  end

  assign in_xfer  = bus.in_valid & adv[0];
  assign out_xfer = v[DEPTH-1] & bus.out_ready;

  assign v_in[0] = in_xfer;
  assign d_in[0] = bus.in_data;

  genvar g;
  generate
    for (g = 1; g < DEPTH; g++) begin : g_link
      assign v_in[g] = v[g-1];
      assign d_in[g] = d[g-1];
    end
    for (g = 0; g < DEPTH; g++) begin : g_stg
      elastic_pipe_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stg (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .adv  (adv[g]),
        .v_in (v_in[g]),
        .d_in (d_in[g]),
        .v    (v[g]),
        .d    (d[g])
      );
    end
  endgenerate

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst || flush)             occupancy <= '0;
    else if (in_xfer && !out_xfer) occupancy <= occupancy + OW'(1);
    else if (!in_xfer && out_xfer) occupancy <= occupancy - OW'(1);
  end
endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: directed cases on a DEPTH=3 pipe plus random traffic on
// DEPTH=3 and DEPTH=1, all outputs checked against a per-instance expected queue.
module tb_elastic_pipe;
  logic clk = 1'b0;
  logic rst;
  logic fl0, fl1;
  logic [1:0] occ0;
  logic [0:0] occ1;
  int total = 0;
  int bad   = 0;
  logic [15:0] q[2][$];

  always #5 clk = ~clk;

  elastic_pipe_if #(.WIDTH(16)) bus0 ();
  elastic_pipe_if #(.WIDTH(16)) bus1 ();

  elastic_pipe #(.WIDTH(16), .DEPTH(3), .RESET_DATA(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .occupancy(occ0), .bus(bus0)
  );
  elastic_pipe #(.WIDTH(16), .DEPTH(1), .RESET_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .occupancy(occ1), .bus(bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endtask

  // Model: entries in the pipe are exactly the queue contents; acceptance is
  // "not full or downstream ready".
  task automatic mon(input int k, input logic iv, input logic ir, input logic [15:0] id,
                     input logic ov, input logic orr, input logic [15:0] od,
                     input logic fl, input logic [31:0] occ, input int dep);
    logic mready;
    logic [15:0] e;
    if (rst) begin
      q[k].delete();
      return;
    end
    mready = (q[k].size() < dep) || orr;
    chk($sformatf("occ%0d", k), occ, q[k].size());
    chk($sformatf("in_ready%0d", k), {31'd0, ir}, {31'd0, mready});
    if (ov === 1'b1 && orr) begin
      total++;
      if (q[k].size() == 0) begin
        bad++;
        $display("FAIL unexpected_out%0d got=%h exp=none @%0t", k, od, $time);
      end else begin
        e = q[k].pop_front();
        if (od !== e) begin
          bad++;
          $display("FAIL out_data%0d got=%h exp=%h @%0t", k, od, e, $time);
        end
      end
    end
    if (fl) q[k].delete();
    else if (iv && mready) q[k].push_back(id);
  endtask

  always @(negedge clk) begin
    mon(0, bus0.in_valid, bus0.in_ready, bus0.in_data, bus0.out_valid, bus0.out_ready,
        bus0.out_data, fl0, {30'd0, occ0}, 3);
    mon(1, bus1.in_valid, bus1.in_ready, bus1.in_data, bus1.out_valid, bus1.out_ready,
        bus1.out_data, fl1, {31'd0, occ1}, 1);
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout got=running exp=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b1; fl0 = 1'b0; fl1 = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ov0", {31'd0, bus0.out_valid}, 0);
    chk("rst_ir0", {31'd0, bus0.in_ready}, 1);
    chk("rst_occ0", {30'd0, occ0}, 0);
    chk("rst_od0", {16'd0, bus0.out_data}, 0);
    chk("rst_ov1", {31'd0, bus1.out_valid}, 0);
    chk("rst_od1", {16'd0, bus1.out_data}, 0);

    // latency: accepted at edge 0, visible after edge 2, gone after edge 3
    bus0.in_valid = 1'b1; bus0.in_data = 16'h1111;
    tick();
    bus0.in_valid = 1'b0;
    chk("lat_occ_e0", {30'd0, occ0}, 1); chk("lat_ov_e0", {31'd0, bus0.out_valid}, 0);
    tick();
    chk("lat_occ_e1", {30'd0, occ0}, 1); chk("lat_ov_e1", {31'd0, bus0.out_valid}, 0);
    tick();
    chk("lat_occ_e2", {30'd0, occ0}, 1); chk("lat_ov_e2", {31'd0, bus0.out_valid}, 1);
    chk("lat_od_e2", {16'd0, bus0.out_data}, 32'h1111);
    tick();
    chk("lat_occ_e3", {30'd0, occ0}, 0); chk("lat_ov_e3", {31'd0, bus0.out_valid}, 0);

    // streaming 0x0001..0x0010 with no gaps once filled
    for (int i = 0; i < 19; i++) begin
      bus0.in_valid = (i < 16);
      bus0.in_data  = 16'(i + 1);
      #1;
      if (i < 16) chk("stream_ir", {31'd0, bus0.in_ready}, 1);
      tick();
      chk("stream_ov", {31'd0, bus0.out_valid}, {31'd0, (i >= 2 && i <= 17)});
    end

    // stall: only A0..A2 fit, A0 held at output
    bus0.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 16'h00A0 + 16'((c < 3) ? c : 3);
      #1;
      chk("stall_ir", {31'd0, bus0.in_ready}, {31'd0, (c < 3)});
      tick();
      if (c >= 2) begin
        chk("stall_ov", {31'd0, bus0.out_valid}, 1);
        chk("stall_od", {16'd0, bus0.out_data}, 32'h00A0);
      end
    end
    chk("stall_occ", {30'd0, occ0}, 3);
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    repeat (4) tick();
    chk("stall_drain_occ", {30'd0, occ0}, 0);

    // bubble collapse: B0, idle, B1 under stall end up adjacent
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 16'h00B0; tick();
    bus0.in_valid = 1'b0; tick();
    bus0.in_valid = 1'b1; bus0.in_data = 16'h00B1; tick();
    bus0.in_valid = 1'b0; tick(); tick();
    chk("bub_occ", {30'd0, occ0}, 2);
    chk("bub_ir", {31'd0, bus0.in_ready}, 1);
    chk("bub_ov", {31'd0, bus0.out_valid}, 1);
    chk("bub_od", {16'd0, bus0.out_data}, 32'h00B0);
    bus0.out_ready = 1'b1;
    repeat (4) tick();
    chk("bub_drain_occ", {30'd0, occ0}, 0);

    // flush a full pipe while presenting C0
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid = 1'b1; bus0.in_data = 16'h00D0 + 16'(i); tick();
    end
    chk("full_occ", {30'd0, occ0}, 3);
    chk("full_ir", {31'd0, bus0.in_ready}, 0);
    fl0 = 1'b1; bus0.in_data = 16'h00C0;
    tick();
    fl0 = 1'b0; bus0.in_valid = 1'b0;
    chk("flush_occ", {30'd0, occ0}, 0);
    chk("flush_ov", {31'd0, bus0.out_valid}, 0);
    chk("flush_od", {16'd0, bus0.out_data}, 0);
    chk("flush_ir", {31'd0, bus0.in_ready}, 1);
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_c0", {31'd0, bus0.out_valid}, 0);
    end

    // reset during a stall
    bus0.out_ready = 1'b0;
    bus0.in_valid = 1'b1; bus0.in_data = 16'h00E0; tick();
    bus0.in_data = 16'h00E1; tick();
    rst = 1'b1; tick();
    rst = 1'b0; bus0.in_valid = 1'b0;
    chk("mrst_occ", {30'd0, occ0}, 0);
    chk("mrst_ov", {31'd0, bus0.out_valid}, 0);
    bus0.out_ready = 1'b1;
    repeat (3) tick();

    // random traffic on both pipes
    for (int n = 0; n < 3000; n++) begin
      bus0.in_valid  = 1'($urandom_range(0, 1));
      bus0.in_data   = 16'($urandom);
      bus0.out_ready = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl0            = ($urandom_range(0, 63) == 0);
      bus1.in_valid  = 1'($urandom_range(0, 1));
      bus1.in_data   = 16'($urandom);
      bus1.out_ready = 1'($urandom_range(0, 1));
      fl1            = ($urandom_range(0, 63) == 0);
      tick();
    end
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1; fl0 = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; fl1 = 1'b0;
    repeat (5) tick();
    chk("rand_left0", q[0].size(), 0);
    chk("rand_left1", q[1].size(), 0);
    chk("rand_occ0", {30'd0, occ0}, 0);
    chk("rand_occ1", {31'd0, occ1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
